// File: rtl/apb_regfile_slave.sv
// apb_regfile_slave
//
// APB completer with a bank of DEPTH byte-strobed read/write registers.
// It answers setup/access transfers on its PSEL line with registered PREADY,
// PSLVERR and PRDATA.
//
// Build option:
//   APB_SLV_WAIT_EN  defined   -> WAIT_CYCLES wait states per transfer
//                               (wait counter and WAIT state are compiled in)
//                    undefined -> every transfer is zero-wait, and
//                               WAIT_CYCLES is ignored
//
// Parameters:
//   DATA_WIDTH     register / PWDATA / PRDATA width in bits
//   ADDRESS_WIDTH  PADDR width (PADDR is a word index)
//   STRB_WIDTH     byte strobes, equal to DATA_WIDTH/8
//   DEPTH          number of registers, at most 2**ADDRESS_WIDTH
//   WAIT_CYCLES    wait states per transfer, 0..15
//
// Ports:
//   PCLK      in   bus clock, rising edge
//   PRESETn   in   asynchronous active-low reset
//   PSEL      in   slave select
//   PENABLE   in   access-phase indicator
//   PWRITE    in   1 = write, 0 = read
//   PADDR     in   register index
//   PWDATA    in   write data
//   PSTRB     in   byte-lane write enables
//   PRDATA    out  read data (registered)
//   PREADY    out  transfer complete (registered)
//   PSLVERR   out  error response, valid while PREADY=1 (registered)
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_IDLE  | no transfer in progress, waiting for a setup phase
// ST_WAIT  | access phase, counting down the wait states (macro builds only)
// ST_READY | response presented, waiting for the completion edge

module apb_regfile_slave #(
    parameter int unsigned DATA_WIDTH    = 32,
    parameter int unsigned ADDRESS_WIDTH = 4,
    parameter int unsigned STRB_WIDTH    = 4,
    parameter int unsigned DEPTH         = 8,
    parameter int unsigned WAIT_CYCLES   = 2
) (
    input  logic                     PCLK,
    input  logic                     PRESETn,
    input  logic                     PSEL,
    input  logic                     PENABLE,
    input  logic                     PWRITE,
    input  logic [ADDRESS_WIDTH-1:0] PADDR,
    input  logic [DATA_WIDTH-1:0]    PWDATA,
    input  logic [STRB_WIDTH-1:0]    PSTRB,
    output logic [DATA_WIDTH-1:0]    PRDATA,
    output logic                     PREADY,
    output logic                     PSLVERR
);

    if ((STRB_WIDTH * 8 != DATA_WIDTH) || (DEPTH > (2 ** ADDRESS_WIDTH)) ||
        (DEPTH == 0) || (WAIT_CYCLES > 15)) begin : g_bad_params
        $error("apb_regfile_slave: illegal parameter combination");
    end

`ifdef APB_SLV_WAIT_EN
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_READY = 2'd2
    } state_t;

    localparam logic [3:0] WAIT_N = 4'(WAIT_CYCLES);
    logic [3:0] wait_cnt;
`else
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READY = 2'd2
    } state_t;
`endif

    state_t state;

    logic [DATA_WIDTH-1:0] regs_q [DEPTH];

    logic                  setup_phase;
    logic                  access_phase;
    logic                  addr_ok;
    logic [DATA_WIDTH-1:0] rd_sel;
    logic [DATA_WIDTH-1:0] resp_data;
    logic                  complete;
    logic                  wr_en;

    assign setup_phase  = PSEL & ~PENABLE;
    assign access_phase = PSEL & PENABLE;

    // Widen the index before comparing so DEPTH == 2**ADDRESS_WIDTH works.
    assign addr_ok = (32'(PADDR) < DEPTH);

    // Index decode as a compare loop: PADDR may be wider than the bank needs
    // and may point past the last register.
    always_comb begin
        rd_sel = '0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            if (PADDR == ADDRESS_WIDTH'(i)) begin
                rd_sel = regs_q[i];
            end
        end
    end

    assign resp_data = (!PWRITE && addr_ok) ? rd_sel : '0;

    assign complete = (state == ST_READY) && access_phase && PREADY;
    assign wr_en    = complete && PWRITE && addr_ok;

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state   <= ST_IDLE;
            PREADY  <= 1'b0;
            PSLVERR <= 1'b0;
            PRDATA  <= '0;
`ifdef APB_SLV_WAIT_EN
            wait_cnt <= 4'd0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    if (setup_phase) begin
`ifdef APB_SLV_WAIT_EN
                        wait_cnt <= WAIT_N;
                        if (WAIT_N != 4'd0) begin
                            state <= ST_WAIT;
                        end else begin
                            state   <= ST_READY;
                            PREADY  <= 1'b1;
                            PSLVERR <= ~addr_ok;
                            PRDATA  <= resp_data;
                        end
`else
                        state   <= ST_READY;
                        PREADY  <= 1'b1;
                        PSLVERR <= ~addr_ok;
                        PRDATA  <= resp_data;
`endif
                    end
                end

`ifdef APB_SLV_WAIT_EN
                ST_WAIT: begin
                    if (!PSEL) begin
                        state    <= ST_IDLE;
                        wait_cnt <= 4'd0;
                        PREADY   <= 1'b0;
                        PSLVERR  <= 1'b0;
                        PRDATA   <= '0;
                    end else if (PENABLE) begin
                        wait_cnt <= wait_cnt - 4'd1;
                        // Last wait cycle: present the response next cycle.
                        if (wait_cnt == 4'd1) begin
                            state   <= ST_READY;
                            PREADY  <= 1'b1;
                            PSLVERR <= ~addr_ok;
                            PRDATA  <= resp_data;
                        end
                    end
                end
`endif

                ST_READY: begin
                    if (!PSEL || (PENABLE && PREADY)) begin
                        // Either an abort or the completion edge.
                        state   <= ST_IDLE;
                        PREADY  <= 1'b0;
                        PSLVERR <= 1'b0;
                        PRDATA  <= '0;
                    end
                end

                default: begin
                    state   <= ST_IDLE;
                    PREADY  <= 1'b0;
                    PSLVERR <= 1'b0;
                    PRDATA  <= '0;
                end
            endcase
        end
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                regs_q[i] <= '0;
            end
        end else if (wr_en) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                if (PADDR == ADDRESS_WIDTH'(i)) begin
                    for (int b = 0; b < int'(STRB_WIDTH); b++) begin
                        if (PSTRB[b]) begin
                            regs_q[i][b*8 +: 8] <= PWDATA[b*8 +: 8];
                        end
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_apb_regfile_slave.sv
module tb_apb_regfile_slave;

    localparam int DW          = 32;
    localparam int AW          = 4;
    localparam int SW          = 4;
    localparam int DEPTH       = 8;
    localparam int WAIT_CYCLES = 2;
`ifdef APB_SLV_WAIT_EN
    localparam int N = WAIT_CYCLES;
`else
    localparam int N = 0;
`endif

    logic          PCLK    = 1'b0;
    logic          PRESETn = 1'b0;
    logic          PSEL    = 1'b0;
    logic          PENABLE = 1'b0;
    logic          PWRITE  = 1'b0;
    logic [AW-1:0] PADDR   = '0;
    logic [DW-1:0] PWDATA  = '0;
    logic [SW-1:0] PSTRB   = '0;
    logic [DW-1:0] PRDATA;
    logic          PREADY;
    logic          PSLVERR;

    apb_regfile_slave #(
        .DATA_WIDTH   (DW),
        .ADDRESS_WIDTH(AW),
        .STRB_WIDTH   (SW),
        .DEPTH        (DEPTH),
        .WAIT_CYCLES  (WAIT_CYCLES)
    ) dut (
        .PCLK   (PCLK),
        .PRESETn(PRESETn),
        .PSEL   (PSEL),
        .PENABLE(PENABLE),
        .PWRITE (PWRITE),
        .PADDR  (PADDR),
        .PWDATA (PWDATA),
        .PSTRB  (PSTRB),
        .PRDATA (PRDATA),
        .PREADY (PREADY),
        .PSLVERR(PSLVERR)
    );

    always #5 PCLK = ~PCLK;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: register contents plus the transfer currently on the bus.
    logic [DW-1:0] mem [DEPTH];
    bit            chk_en    = 1'b0;
    bit            in_access = 1'b0;
    int            acc_cnt   = 0;
    bit            cur_write = 1'b0;
    int            cur_addr  = 0;

    task automatic check(input string name, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h expected=%h", name, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] model_rd(input int a);
        if (a >= 0 && a < DEPTH) return mem[a];
        return '0;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < DEPTH; i++) mem[i] = '0;
    endtask

    // Outputs are meaningful only in access cycle N+1; everywhere else zero.
    always @(negedge PCLK) begin
        if (chk_en) begin
            bit            e_rdy;
            bit            e_err;
            logic [DW-1:0] e_dat;
            e_rdy = in_access && (acc_cnt == N + 1);
            e_err = e_rdy && (cur_addr >= DEPTH);
            e_dat = (e_rdy && !cur_write && !e_err) ? model_rd(cur_addr) : '0;
            check("cyc_pready",  DW'(PREADY),  DW'(e_rdy));
            check("cyc_pslverr", DW'(PSLVERR), DW'(e_err));
            check("cyc_prdata",  PRDATA,       e_dat);
        end
    end

    // Called at posedge+1; returns at posedge+1 after the completion edge, so
    // a following call issues its setup phase with no idle cycle in between.
    task automatic xfer(input bit wr, input int addr, input logic [DW-1:0] wd,
                        input logic [SW-1:0] st, output logic [DW-1:0] rd,
                        output logic err, output int nacc);
        bit done;
        done = 1'b0;
        rd   = '0;
        err  = 1'b0;
        nacc = 0;
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = wr; PADDR = AW'(addr);
        PWDATA = wd; PSTRB = st;
        cur_write = wr; cur_addr = addr; in_access = 1'b0; acc_cnt = 0;
        @(posedge PCLK); #1;
        PENABLE = 1'b1; in_access = 1'b1; acc_cnt = 1;
        for (int k = 0; k < 20 && !done; k++) begin
            @(negedge PCLK);
            if (PREADY) begin
                done = 1'b1; rd = PRDATA; err = PSLVERR; nacc = acc_cnt;
            end
            @(posedge PCLK); #1;
            if (!done) acc_cnt++;
        end
        n_checks++;
        if (!done) begin
            n_fail++;
            $display("FAIL xfer_timeout addr=%0d got=no_pready expected=pready_within_20", addr);
        end else if (wr && addr < DEPTH) begin
            for (int b = 0; b < SW; b++)
                if (st[b]) mem[addr][b*8 +: 8] = wd[b*8 +: 8];
        end
        PSEL = 1'b0; PENABLE = 1'b0; in_access = 1'b0; acc_cnt = 0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge PCLK); #1;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DW-1:0] rd;
        logic          err;
        int            nacc;

        model_clear();
        #12;
        check("rst_pready",  DW'(PREADY),  '0);
        check("rst_pslverr", DW'(PSLVERR), '0);
        check("rst_prdata",  PRDATA,       '0);
        @(posedge PCLK); #1;
        PRESETn = 1'b1;
        chk_en  = 1'b1;
        idle(1);

        // write 240 then read back
        xfer(1'b1, 1, 32'd240, 4'b1111, rd, err, nacc);
        check("wr1_latency", DW'(nacc), DW'(N + 1));
        check("wr1_err",     DW'(err),  '0);
        xfer(1'b0, 1, '0, 4'b0000, rd, err, nacc);
        check("rd1_data",    rd,        32'd240);
        check("rd1_latency", DW'(nacc), DW'(N + 1));
        check("rd1_err",     DW'(err),  '0);

        // byte strobes
        xfer(1'b1, 3, 32'h1122_3344, 4'b1111, rd, err, nacc);
        xfer(1'b1, 3, 32'hAABB_CCDD, 4'b0101, rd, err, nacc);
        xfer(1'b0, 3, '0, 4'b1111, rd, err, nacc);
        check("strb_data", rd, 32'h11BB_33DD);

        // read of index 1 holding 15, latency N+1
        idle(2);
        xfer(1'b1, 1, 32'd15, 4'b1111, rd, err, nacc);
        xfer(1'b0, 1, '0, 4'b0000, rd, err, nacc);
        check("rd15_data",    rd,        32'd15);
        check("rd15_latency", DW'(nacc), DW'(N + 1));

        // zero-strobe write changes nothing
        xfer(1'b1, 1, 32'hFFFF_FFFF, 4'b0000, rd, err, nacc);
        check("strb0_err", DW'(err), '0);
        xfer(1'b0, 1, '0, 4'b0000, rd, err, nacc);
        check("strb0_data", rd, 32'd15);

        // out of range
        xfer(1'b1, 15, 32'hFFFF_FFFF, 4'b1111, rd, err, nacc);
        check("oob_wr_err", DW'(err), 32'd1);
        xfer(1'b0, 7, '0, 4'b0000, rd, err, nacc);
        check("idx7_data", rd,       '0);
        check("idx7_err",  DW'(err), '0);
        xfer(1'b0, 15, '0, 4'b0000, rd, err, nacc);
        check("oob_rd_err",  DW'(err), 32'd1);
        check("oob_rd_data", rd,       '0);

        // back-to-back write then read
        xfer(1'b1, 2, 32'd5, 4'b1111, rd, err, nacc);
        xfer(1'b0, 2, '0, 4'b0000, rd, err, nacc);
        check("b2b_data", rd, 32'd5);

        // reset in the middle of a write
        idle(1);
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = '0;
        PWDATA = 32'hDEAD_BEEF; PSTRB = 4'b1111;
        cur_write = 1'b1; cur_addr = 0; in_access = 1'b0;
        @(posedge PCLK); #1;
        PENABLE = 1'b1;
        chk_en  = 1'b0;
        #2;
        PRESETn = 1'b0;
        #1;
        check("rst_mid_pready",  DW'(PREADY), '0);
        check("rst_mid_prdata",  PRDATA,      '0);
        @(posedge PCLK); #1;
        PSEL = 1'b0; PENABLE = 1'b0; PRESETn = 1'b1;
        model_clear();
        in_access = 1'b0;
        chk_en    = 1'b1;
        idle(1);
        xfer(1'b0, 0, '0, 4'b0000, rd, err, nacc);
        check("rst_idx0_data", rd, '0);

        // PSEL dropped mid-transfer
        xfer(1'b1, 0, 32'h1234_5678, 4'b1111, rd, err, nacc);
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = '0;
        PWDATA = 32'hDEAD_BEEF; PSTRB = 4'b1111;
        cur_write = 1'b1; cur_addr = 0; in_access = 1'b0;
        @(posedge PCLK); #1;
        chk_en = 1'b0;
        PSEL = 1'b0; PENABLE = 1'b0;
        @(posedge PCLK); #1;
        chk_en = 1'b1;
        check("abort_pready", DW'(PREADY), '0);
        idle(1);
        xfer(1'b0, 0, '0, 4'b0000, rd, err, nacc);
        check("abort_idx0_data", rd, 32'h1234_5678);

        idle(2);
        chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
